// File: rtl/mux_pkg.sv
// Shared constants and types for the 2:1 mux primitive.
//   DEFAULT_WIDTH : default data width of d0/d1/y/y_q
//   DEFAULT_CNT_W : default width of the select-transition counter
//   word_t        : data word at the default width
package mux_pkg;

   localparam int unsigned DEFAULT_WIDTH = 1;
   localparam int unsigned DEFAULT_CNT_W = 8;

   typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage : mux_pkg

// File: rtl/mux_2to1_if.sv
// Bus bundle for mux_2to1.
//   d0, d1 : data inputs (WIDTH)
//   s      : select
//   en     : register enable for y_q/sel_q/sw_cnt
//   y      : combinational mux output (WIDTH)
//   y_q    : registered mux output (WIDTH)
//   sel_q  : registered select
//   sw_cnt : saturating count of select transitions (CNT_W)
// master drives the data/control side, slave is the mux itself.
interface mux_2to1_if
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = DEFAULT_CNT_W
);

   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic             s;
   logic             en;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] y_q;
   logic             sel_q;
   logic [CNT_W-1:0] sw_cnt;

   modport master (
      output d0, d1, s, en,
      input  y, y_q, sel_q, sw_cnt
   );

   modport slave (
      input  d0, d1, s, en,
      output y, y_q, sel_q, sw_cnt
   );

endinterface : mux_2to1_if

// File: rtl/mux_out_reg.sv
// Enabled output register for the mux plus saturating select-transition counter.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : load enable for all registers
//   d          : mux result to capture
//   s          : select to capture and compare against the stored select
//   y_q        : registered mux result
//   sel_q      : registered select
//   sw_cnt     : count of captured select changes, sticks at all-ones
module mux_out_reg
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   input  logic             s,
   output logic [WIDTH-1:0] y_q,
   output logic             sel_q,
   output logic [CNT_W-1:0] sw_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] y_d;
   logic             sel_d;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Next-state: hold unless enabled; count only a change against the stored select.
   always_comb begin
      y_d   = y_q;
      sel_d = sel_q;
      cnt_d = cnt_q;
      if (en) begin
         y_d   = d;
         sel_d = s;
         if ((s != sel_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State register; reset takes priority over the enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q   <= '0;
         sel_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         y_q   <= y_d;
         sel_q <= sel_d;
         cnt_q <= cnt_d;
      end
   end

   assign sw_cnt = cnt_q;

endmodule : mux_out_reg

// File: rtl/mux_2to1.sv
// Parameterised 2:1 selector with zero-latency output and a registered copy.
//   clk, rst_n : clock, synchronous active-low reset (registered path only)
//   bus        : mux_2to1_if slave - d0/d1/s/en in, y/y_q/sel_q/sw_cnt out
// y never depends on clk, rst_n or en.
module mux_2to1
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
   input  logic       clk,
   input  logic       rst_n,
   mux_2to1_if.slave  bus
);

   // Combinational select.
   assign bus.y = bus.s ? bus.d1 : bus.d0;

   // Registered copy of the selected data and select history.
   mux_out_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_out_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (bus.en),
      .d      (bus.y),
      .s      (bus.s),
      .y_q    (bus.y_q),
      .sel_q  (bus.sel_q),
      .sw_cnt (bus.sw_cnt)
   );

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: one narrow instance for the no-clock truth
// table, plus 8-bit instances with 8-bit and 2-bit counters sharing stimulus.
module tb_mux_2to1;

   logic clk;
   logic clk_run;
   logic rst_n;
   int   total;
   int   bad;

   // Reference state: index 0 = 8-bit counter instance, 1 = 2-bit counter instance.
   logic [7:0] m_yq  [2];
   logic       m_sel [2];
   int         m_cnt [2];
   int         m_max [2];

   mux_2to1_if #(.WIDTH(1), .CNT_W(8)) if1 ();
   mux_2to1_if #(.WIDTH(8), .CNT_W(8)) if8 ();
   mux_2to1_if #(.WIDTH(8), .CNT_W(2)) ifs ();

   mux_2to1 #(.WIDTH(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   mux_2to1 #(.WIDTH(8), .CNT_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   mux_2to1 #(.WIDTH(8), .CNT_W(2)) u_duts (.clk(clk), .rst_n(rst_n), .bus(ifs));

   initial begin
      clk = 1'b0;
      wait (clk_run === 1'b1);
      forever #5 clk = ~clk;
   end

   // Same data/control to both clocked instances.
   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sel, input logic e);
      if8.d0 = a; if8.d1 = b; if8.s = sel; if8.en = e;
      ifs.d0 = a; ifs.d1 = b; ifs.s = sel; ifs.en = e;
   endtask

   // Behavioural effect of one rising edge on the reference state.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (rst_n !== 1'b1) begin
            m_yq[k] = 8'h00; m_sel[k] = 1'b0; m_cnt[k] = 0;
         end else if (if8.en) begin
            if (if8.s != m_sel[k]) m_cnt[k] = (m_cnt[k] < m_max[k]) ? m_cnt[k] + 1 : m_cnt[k];
            m_yq[k]  = if8.s ? if8.d1 : if8.d0;
            m_sel[k] = if8.s;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_comb();
      logic [2:0] vec [4];
      logic [7:0] a, b;
      vec = '{3'b010, 3'b011, 3'b101, 3'b100}; // {d0,d1,s}
      if1.en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if1.d0 = vec[i][2]; if1.d1 = vec[i][1]; if1.s = vec[i][0];
         #1;
         if (if1.y !== (vec[i][0] ? vec[i][1] : vec[i][2])) begin
            bad++; $display("FAIL comb_w1[%0d] y=%b exp=%b", i, if1.y, vec[i][0] ? vec[i][1] : vec[i][2]);
         end
         total++;
      end
      for (int i = 0; i < 6; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         drive(a, b, 1'($urandom), 1'b0);
         #1;
         if (if8.y !== (if8.s ? b : a)) begin
            bad++; $display("FAIL comb_w8[%0d] y=%h exp=%h", i, if8.y, if8.s ? b : a);
         end
         total++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(8'h5A, 8'hC3, 1'b1, 1'b1);
      tick(); tick();
      if (if8.y_q !== 8'h00 || if8.sel_q !== 1'b0 || if8.sw_cnt !== 8'd0) begin
         bad++; $display("FAIL reset_hold y_q=%h sel_q=%b cnt=%0d exp 0/0/0", if8.y_q, if8.sel_q, if8.sw_cnt);
      end
      total++;
      if (ifs.y_q !== 8'h00 || ifs.sel_q !== 1'b0 || ifs.sw_cnt !== 2'd0) begin
         bad++; $display("FAIL reset_hold_sat y_q=%h sel_q=%b cnt=%0d exp 0/0/0", ifs.y_q, ifs.sel_q, ifs.sw_cnt);
      end
      total++;
      rst_n = 1'b1;
      tick();
      if (if8.sel_q !== 1'b1 || if8.sw_cnt !== 8'd1 || if8.y_q !== 8'hC3) begin
         bad++; $display("FAIL reset_release sel_q=%b cnt=%0d y_q=%h exp 1/1/c3", if8.sel_q, if8.sw_cnt, if8.y_q);
      end
      total++;
   endtask

   task automatic test_wide();
      logic sel;
      sel = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(8'hA5, 8'h3C, sel, 1'b1);
         #1;
         if (if8.y !== (sel ? 8'h3C : 8'hA5)) begin
            bad++; $display("FAIL wide_y[%0d] y=%h exp=%h", i, if8.y, sel ? 8'h3C : 8'hA5);
         end
         total++;
         tick();
         if (if8.y_q !== m_yq[0] || if8.y_q !== (sel ? 8'h3C : 8'hA5)) begin
            bad++; $display("FAIL wide_yq[%0d] y_q=%h exp=%h", i, if8.y_q, m_yq[0]);
         end
         total++;
         sel = ~sel;
      end
   endtask

   task automatic test_enable_hold();
      logic [7:0] yq0;
      logic       sel0;
      logic [7:0] cnt0;
      logic [7:0] a, b;
      logic       sel;
      yq0 = m_yq[0]; sel0 = m_sel[0]; cnt0 = 8'(m_cnt[0]);
      for (int i = 0; i < 3; i++) begin
         a = 8'($urandom); b = 8'($urandom); sel = ~if8.sel_q ^ 1'(i);
         drive(a, b, sel, 1'b0);
         #1;
         if (if8.y !== (sel ? b : a)) begin
            bad++; $display("FAIL hold_y[%0d] y=%h exp=%h", i, if8.y, sel ? b : a);
         end
         total++;
         tick();
         if (if8.y_q !== yq0 || if8.sel_q !== sel0 || if8.sw_cnt !== cnt0) begin
            bad++; $display("FAIL hold_regs[%0d] y_q=%h sel_q=%b cnt=%0d exp %h/%b/%0d",
                            i, if8.y_q, if8.sel_q, if8.sw_cnt, yq0, sel0, cnt0);
         end
         total++;
      end
   endtask

   task automatic test_saturation();
      int exp_seq [5];
      exp_seq = '{1, 2, 3, 3, 3};
      rst_n = 1'b0;
      drive(8'h11, 8'h22, 1'b0, 1'b1);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(8'($urandom), 8'($urandom), (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
         tick();
         if (int'(ifs.sw_cnt) !== exp_seq[i] || int'(ifs.sw_cnt) !== m_cnt[1]) begin
            bad++; $display("FAIL sat_cnt[%0d] cnt=%0d exp=%0d", i, ifs.sw_cnt, exp_seq[i]);
         end
         total++;
      end
      if (int'(if8.sw_cnt) !== 5) begin
         bad++; $display("FAIL wide_cnt cnt=%0d exp=5", if8.sw_cnt);
      end
      total++;
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      drive(8'h0F, 8'hF0, 1'b0, 1'b1);
      tick();
      rst_n = 1'b1;
      drive(8'h0F, 8'hF0, 1'b1, 1'b1); tick();
      drive(8'h0F, 8'hF0, 1'b0, 1'b1); tick();
      if (if8.sw_cnt !== 8'd2) begin
         bad++; $display("FAIL mid_precnt cnt=%0d exp=2", if8.sw_cnt);
      end
      total++;
      rst_n = 1'b0;
      drive(8'h0F, 8'hF0, 1'b1, 1'b1);
      tick();
      if (if8.y_q !== 8'h00 || if8.sel_q !== 1'b0 || if8.sw_cnt !== 8'd0) begin
         bad++; $display("FAIL mid_reset y_q=%h sel_q=%b cnt=%0d exp 0/0/0", if8.y_q, if8.sel_q, if8.sw_cnt);
      end
      total++;
      if (if8.y !== 8'hF0) begin
         bad++; $display("FAIL mid_reset_y y=%h exp=f0", if8.y);
      end
      total++;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] a, b;
      logic       sel, e;
      for (int i = 0; i < 300; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         sel = ($urandom_range(0, 3) == 0) ? ~if8.s : if8.s;
         e = ($urandom_range(0, 3) != 0);
         rst_n = ($urandom_range(0, 39) != 0);
         drive(a, b, sel, e);
         #1;
         if (if8.y !== (sel ? b : a)) begin
            bad++; $display("FAIL rand_y[%0d] y=%h exp=%h", i, if8.y, sel ? b : a);
         end
         total++;
         tick();
         if (if8.y_q !== m_yq[0] || if8.sel_q !== m_sel[0] || int'(if8.sw_cnt) !== m_cnt[0]) begin
            bad++; $display("FAIL rand_w8[%0d] y_q=%h sel_q=%b cnt=%0d exp %h/%b/%0d",
                            i, if8.y_q, if8.sel_q, if8.sw_cnt, m_yq[0], m_sel[0], m_cnt[0]);
         end
         total++;
         if (ifs.y_q !== m_yq[1] || ifs.sel_q !== m_sel[1] || int'(ifs.sw_cnt) !== m_cnt[1]) begin
            bad++; $display("FAIL rand_sat[%0d] y_q=%h sel_q=%b cnt=%0d exp %h/%b/%0d",
                            i, ifs.y_q, ifs.sel_q, ifs.sw_cnt, m_yq[1], m_sel[1], m_cnt[1]);
         end
         total++;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0; bad = 0;
      clk_run = 1'b0;
      m_max[0] = 255; m_max[1] = 3;
      for (int k = 0; k < 2; k++) begin
         m_yq[k] = 8'h00; m_sel[k] = 1'b0; m_cnt[k] = 0;
      end
      test_comb();
      clk_run = 1'b1;
      #2;
      test_reset();
      test_wide();
      test_enable_hold();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mux_2to1
